// File: rtl/tx_msg_scheduler.sv
// Round-robin scheduler that serialises RGF, single-pixel and burst requests
// onto the shared TX message composer and tracks the TX MAC busy handshake.
module tx_msg_scheduler #(
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rgf_req_in,
  input  logic [31:0] rgf_addr_in,
  input  logic [31:0] rgf_data_in,
  output logic        rgf_done,
  input  logic        sgl_req_in,
  input  logic [13:0] sgl_row_in,
  input  logic [13:0] sgl_col_in,
  input  logic [23:0] sgl_pixel_in,
  output logic        sgl_done,
  input  logic        bst_req_in,
  input  logic [31:0] bst_red_in,
  input  logic [31:0] bst_green_in,
  input  logic [31:0] bst_blue_in,
  output logic        bst_done,
  input  logic        tx_mac_busy,
  output logic        now_rgf_read,
  output logic        now_image_read_single,
  output logic        now_image_read_burst,
  output logic [31:0] rgf_raw_address,
  output logic [31:0] rgf_data,
  output logic [13:0] img_row_counter,
  output logic [13:0] img_col_counter,
  output logic [23:0] pixel_cell,
  output logic [31:0] red_burst_data,
  output logic [31:0] green_burst_data,
  output logic [31:0] blue_burst_data,
  output logic        to_cmpsr_start_req,
  output logic        sched_busy,
  output logic        overrun_err,
  output logic        timeout_err
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(BUSY_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST  = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE
  } state_t;

  typedef enum logic [1:0] {
    SRC_RGF = 2'd0, SRC_SGL = 2'd1, SRC_BST = 2'd2
  } src_t;

  function automatic src_t rr_next(input src_t s);
    case (s)
      SRC_RGF: return SRC_SGL;
      SRC_SGL: return SRC_BST;
      default: return SRC_RGF;
    endcase
  endfunction

  state_t        state, state_nxt;
  src_t          grant, rr_ptr, pick, cand1, cand2;
  logic          pick_valid;
  logic [2:0]    pending, req, accept, drop, done_q, clear_mask;
  logic [CW-1:0] busy_cnt;
  logic          timeout_hit, complete;

  assign req    = {bst_req_in, sgl_req_in, rgf_req_in};
  assign accept = req & ~pending;
  assign drop   = req & pending;

  assign cand1 = rr_next(rr_ptr);
  assign cand2 = rr_next(cand1);

  assign timeout_hit = (state == S_WAIT_BUSY) && !tx_mac_busy && (busy_cnt >= TO_LAST);
  assign complete    = timeout_hit || ((state == S_WAIT_DONE) && !tx_mac_busy);
  assign clear_mask  = complete ? (3'b001 << grant) : 3'b000;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_valid = |pending;
    pick       = cand2;
    if (pending[rr_ptr])     pick = rr_ptr;
    else if (pending[cand1]) pick = cand1;

    state_nxt = state;
    case (state)
      S_IDLE:      if (pick_valid) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_START;
      S_START:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_mac_busy)      state_nxt = S_WAIT_DONE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!tx_mac_busy) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant       <= SRC_RGF;
      rr_ptr      <= SRC_RGF;
      pending     <= '0;
      busy_cnt    <= '0;
      done_q      <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= (pending | accept) & ~clear_mask;
      done_q      <= clear_mask;
      timeout_err <= timeout_hit;
      overrun_err <= |drop;
      if (state == S_IDLE && pick_valid) begin
        grant  <= pick;
        rr_ptr <= rr_next(pick);
      end
      // Counter saturates at the limit so a stuck MAC can never wrap it.
      if (state == S_START)
        busy_cnt <= '0;
      else if (state == S_WAIT_BUSY && !tx_mac_busy && busy_cnt != TO_LIMIT)
        busy_cnt <= busy_cnt + CW'(1);
    end
  end

  // NOTE: holding registers are reset because the composer may read them right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgf_raw_address  <= '0;
      rgf_data         <= '0;
      img_row_counter  <= '0;
      img_col_counter  <= '0;
      pixel_cell       <= '0;
      red_burst_data   <= '0;
      green_burst_data <= '0;
      blue_burst_data  <= '0;
    end else begin
      if (accept[SRC_RGF]) begin
        rgf_raw_address <= rgf_addr_in;
        rgf_data        <= rgf_data_in;
      end
      if (accept[SRC_SGL]) begin
        img_row_counter <= sgl_row_in;
        img_col_counter <= sgl_col_in;
        pixel_cell      <= sgl_pixel_in;
      end
      if (accept[SRC_BST]) begin
        red_burst_data   <= bst_red_in;
        green_burst_data <= bst_green_in;
        blue_burst_data  <= bst_blue_in;
      end
    end
  end

  assign sched_busy            = (state != S_IDLE);
  assign to_cmpsr_start_req    = (state == S_START);
  assign now_rgf_read          = sched_busy && (grant == SRC_RGF);
  assign now_image_read_single = sched_busy && (grant == SRC_SGL);
  assign now_image_read_burst  = sched_busy && (grant == SRC_BST);
  assign rgf_done              = done_q[SRC_RGF];
  assign sgl_done              = done_q[SRC_SGL];
  assign bst_done              = done_q[SRC_BST];

endmodule
